// File: rtl/writeback_retire_if.sv
// Completion bus between three functional units and the writeback/retire stage.
// Carries the per-unit result handshakes and the register-file / scoreboard retire strobes.
interface writeback_retire_if #(
   parameter int DATA_W = 32
);
   logic [2:0]          fu_wb_valid;
   logic [2:0]          fu_wb_ready;
   logic [14:0]         fu_wb_regdest;
   logic [3*DATA_W-1:0] fu_wb_data;
   logic [2:0]          fu_wb_writereg;
   logic [2:0]          fu_wb_ovkill;
   logic                wb_reg_we;
   logic [4:0]          wb_reg_addr;
   logic [DATA_W-1:0]   wb_reg_data;
   logic                wb_sb_clr;
   logic [4:0]          wb_sb_addr;
   logic [1:0]          wb_sb_fununit;
   logic                wb_busy;

   modport master (
      output fu_wb_valid, fu_wb_regdest, fu_wb_data, fu_wb_writereg, fu_wb_ovkill,
      input  fu_wb_ready, wb_reg_we, wb_reg_addr, wb_reg_data,
      input  wb_sb_clr, wb_sb_addr, wb_sb_fununit, wb_busy
   );

   modport slave (
      input  fu_wb_valid, fu_wb_regdest, fu_wb_data, fu_wb_writereg, fu_wb_ovkill,
      output fu_wb_ready, wb_reg_we, wb_reg_addr, wb_reg_data,
      output wb_sb_clr, wb_sb_addr, wb_sb_fununit, wb_busy
   );
endinterface

// File: rtl/writeback_retire.sv
// Buffers results from three functional units and retires the oldest one per cycle to the
// register file and scoreboard; one cycle accept-to-retire latency, ready = per-unit FIFO not full.
module writeback_retire #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 32,
   parameter int SEQ_W  = 4
) (
   input  logic clock,
   input  logic reset,
   writeback_retire_if.slave wb
);
   localparam int PW = $clog2(DEPTH) + 1;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [4:0]        regdest;
      logic [DATA_W-1:0] data;
      logic              writereg;
      logic              ovkill;
      logic [SEQ_W-1:0]  seq;
   } entry_t;

   entry_t           mem [3][DEPTH];
   logic [PW-1:0]    wr_ptr [3];
   logic [PW-1:0]    rd_ptr [3];
   logic [2:0]       full, empty, push, pop;
   entry_t           head [3];
   logic [SEQ_W-1:0] seq, seq_next;
   logic [SEQ_W-1:0] push_seq [3];
   entry_t           sel;
   logic [1:0]       sel_fu;
   logic             any_pop;

   logic              reg_we, sb_clr, busy;
   logic [4:0]        ret_addr;
   logic [DATA_W-1:0] ret_data;
   logic [1:0]        ret_fu;

   function automatic logic [IW-1:0] slot(input logic [PW-1:0] p);
      return IW'(p % PW'(DEPTH));
   endfunction

   // a is older than b when b lies within the forward half-window after a
   function automatic logic older(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
      logic [SEQ_W-1:0] d;
      d = b - a;
      return (d != '0) && !d[SEQ_W-1];
   endfunction

   always_comb begin
      seq_next = seq;
      for (int i = 0; i < 3; i++) begin
         empty[i]    = (wr_ptr[i] == rd_ptr[i]);
         full[i]     = ((wr_ptr[i] - rd_ptr[i]) == PW'(DEPTH));
         head[i]     = mem[i][slot(rd_ptr[i])];
         push[i]     = wb.fu_wb_valid[i] && !full[i];
         push_seq[i] = seq_next;
         seq_next    = seq_next + SEQ_W'(push[i]);
      end
   end

   always_comb begin
      pop    = '0;
      sel    = head[0];
      sel_fu = 2'd1;
      for (int i = 0; i < 3; i++) begin
         pop[i] = !empty[i];
         for (int j = 0; j < 3; j++) begin
            if (j != i && !empty[j] && !older(head[i].seq, head[j].seq)) begin
               pop[i] = 1'b0;
            end
         end
         if (pop[i]) begin
            sel    = head[i];
            sel_fu = 2'(i + 1);
         end
      end
      any_pop = |pop;
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < 3; i++) begin
         if (push[i]) begin
            mem[i][slot(wr_ptr[i])] <= '{regdest:  wb.fu_wb_regdest[i*5 +: 5],
                                         data:     wb.fu_wb_data[i*DATA_W +: DATA_W],
                                         writereg: wb.fu_wb_writereg[i],
                                         ovkill:   wb.fu_wb_ovkill[i],
                                         seq:      push_seq[i]};
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 3; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
         end
         seq      <= '0;
         reg_we   <= 1'b0;
         sb_clr   <= 1'b0;
         ret_addr <= '0;
         ret_data <= '0;
         ret_fu   <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
         end
         seq    <= seq_next;
         sb_clr <= any_pop;
         reg_we <= any_pop && sel.writereg && !sel.ovkill && (sel.regdest != 5'd0);
         if (any_pop) begin
            ret_addr <= sel.regdest;
            ret_data <= sel.data;
            ret_fu   <= sel_fu;
         end
      end
   end

   assign busy              = ~&empty;
   assign wb.fu_wb_ready    = ~full;
   assign wb.wb_reg_we      = reg_we;
   assign wb.wb_reg_addr    = ret_addr;
   assign wb.wb_reg_data    = ret_data;
   assign wb.wb_sb_clr      = sb_clr;
   assign wb.wb_sb_addr     = ret_addr;
   assign wb.wb_sb_fununit  = ret_fu;
   assign wb.wb_busy        = busy;
endmodule

// File: tb/tb_writeback_retire.sv
// Bench for writeback_retire: directed scenarios plus random traffic against an
// acceptance-ordered queue model of the retire stream.
module tb_writeback_retire;
   localparam int DEPTH  = 2;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   writeback_retire_if #(.DATA_W(DATA_W)) ifc ();

   writeback_retire #(.DEPTH(DEPTH), .DATA_W(DATA_W), .SEQ_W(4)) dut (
      .clock (clk),
      .reset (rst_n),
      .wb    (ifc.slave)
   );

   typedef struct {
      int          ch;
      logic [4:0]  rd;
      logic [31:0] d;
      logic        wr;
      logic        ok;
   } ent_t;

   ent_t        q[$];
   int          cnt [3];
   logic [31:0] rf [32];
   logic [31:0] obs7[$];

   logic        exp_we, exp_clr;
   logic [4:0]  exp_addr;
   logic [31:0] exp_data;
   logic [1:0]  exp_fu;
   logic [2:0]  exp_ready, obs_ready;
   logic [46:0] exp_out, obs_out;

   int checks = 0;
   int errors = 0;

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < 3; i++) cnt[i] = 0;
      exp_we = 0; exp_clr = 0; exp_addr = 0; exp_data = 0; exp_fu = 0;
      exp_out = '0;
   endtask

   function automatic logic [46:0] pack_obs();
      return {ifc.wb_reg_we, ifc.wb_reg_addr, ifc.wb_reg_data, ifc.wb_sb_clr,
              ifc.wb_sb_addr, ifc.wb_sb_fununit, ifc.wb_busy};
   endfunction

   // One clock: drive inputs at the falling edge, advance the model across the rising edge,
   // sample outputs 1ns later and return to the falling edge.
   task automatic step(input logic [2:0] v, input logic [14:0] rd, input logic [95:0] d,
                       input logic [2:0] wr, input logic [2:0] ok);
      logic [2:0] acc;
      ent_t e;
      ifc.fu_wb_valid = v; ifc.fu_wb_regdest = rd; ifc.fu_wb_data = d;
      ifc.fu_wb_writereg = wr; ifc.fu_wb_ovkill = ok;
      #1;
      obs_ready = ifc.fu_wb_ready;
      for (int i = 0; i < 3; i++) begin
         exp_ready[i] = (cnt[i] < DEPTH);
         acc[i] = v[i] && exp_ready[i];
      end
      @(posedge clk);
      exp_we = 0; exp_clr = 0;
      if (q.size() > 0) begin
         e = q.pop_front();
         cnt[e.ch]--;
         exp_clr = 1; exp_addr = e.rd; exp_data = e.d; exp_fu = 2'(e.ch + 1);
         exp_we = e.wr && !e.ok && (e.rd != 0);
         if (exp_we) rf[e.rd] = e.d;
      end
      for (int i = 0; i < 3; i++) begin
         if (acc[i]) begin
            q.push_back('{ch: i, rd: rd[i*5 +: 5], d: d[i*32 +: 32], wr: wr[i], ok: ok[i]});
            cnt[i]++;
         end
      end
      exp_out = {exp_we, exp_addr, exp_data, exp_clr, exp_addr, exp_fu, (q.size() > 0)};
      #1;
      obs_out = pack_obs();
      if (ifc.wb_reg_we && ifc.wb_reg_addr == 5'd7) obs7.push_back(ifc.wb_reg_data);
      @(negedge clk);
   endtask

   task automatic idle();
      step(3'b000, '0, '0, 3'b000, 3'b000);
   endtask

   task automatic test_reset();
      model_reset();
      ifc.fu_wb_valid = '0; ifc.fu_wb_regdest = '0; ifc.fu_wb_data = '0;
      ifc.fu_wb_writereg = '0; ifc.fu_wb_ovkill = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (pack_obs() !== 47'd0) begin
         errors++; $display("FAIL reset_outputs: got %h expected 0", pack_obs());
      end
      checks++;
      if (ifc.fu_wb_ready !== 3'b111) begin
         errors++; $display("FAIL reset_ready: got %b expected 111", ifc.fu_wb_ready);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      step(3'b001, 15'd5, 96'h1234, 3'b001, 3'b000);
      checks++;
      if (obs_out !== exp_out) begin
         errors++; $display("FAIL single_accept: got %h expected %h", obs_out, exp_out);
      end
      idle();
      checks++;
      if (obs_out !== {1'b1, 5'd5, 32'h1234, 1'b1, 5'd5, 2'd1, 1'b0}) begin
         errors++; $display("FAIL single_retire: got %h expected %h", obs_out,
                            {1'b1, 5'd5, 32'h1234, 1'b1, 5'd5, 2'd1, 1'b0});
      end
      idle();
      checks++;
      if (ifc.wb_reg_we !== 1'b0 || ifc.wb_sb_clr !== 1'b0 || obs_out !== exp_out) begin
         errors++; $display("FAIL single_strobe_drop: got %h expected %h", obs_out, exp_out);
      end
   endtask

   task automatic test_all_three();
      step(3'b111, {5'd5, 5'd4, 5'd3}, {32'hC3, 32'hB2, 32'hA1}, 3'b111, 3'b000);
      for (int k = 1; k <= 3; k++) begin
         idle();
         checks++;
         if (obs_out !== exp_out || ifc.wb_sb_fununit !== 2'(k) || ifc.wb_sb_addr !== 5'(k + 2)) begin
            errors++; $display("FAIL three_order_%0d: got %h expected %h", k, obs_out, exp_out);
         end
      end
      checks++;
      if (ifc.wb_busy !== 1'b0) begin
         errors++; $display("FAIL three_busy: got %b expected 0", ifc.wb_busy);
      end
   endtask

   task automatic test_waw();
      obs7.delete();
      step(3'b110, {5'd10, 5'd7, 5'd0}, {32'h3333, 32'hAAAA, 32'h0}, 3'b111, 3'b000);
      step(3'b001, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'hBBBB}, 3'b001, 3'b000);
      repeat (3) begin
         idle();
         checks++;
         if (obs_out !== exp_out) begin
            errors++; $display("FAIL waw_stream: got %h expected %h", obs_out, exp_out);
         end
      end
      checks++;
      if (obs7.size() != 2 || obs7[0] !== 32'hAAAA || obs7[1] !== 32'hBBBB || rf[7] !== 32'hBBBB) begin
         errors++; $display("FAIL waw_order: got %0d writes last=%h expected A then B", obs7.size(),
                            (obs7.size() > 0) ? obs7[obs7.size()-1] : 32'h0);
      end
   endtask

   task automatic test_full();
      int hits = 0;
      for (int c = 0; c < 14; c++) begin
         step(3'b111, 15'($urandom), {$urandom, $urandom, $urandom}, 3'b111, 3'b000);
         checks++;
         if (obs_ready !== exp_ready || obs_out !== exp_out) begin
            errors++; $display("FAIL full_cycle_%0d: ready %b/%b out %h expected %h",
                               c, obs_ready, exp_ready, obs_out, exp_out);
         end
         if (obs_ready[0] == 1'b0 && ifc.wb_sb_clr && ifc.wb_sb_fununit == 2'd1) hits++;
      end
      checks++;
      if (hits == 0) begin
         errors++; $display("FAIL full_ready_in_pop: got %0d blocked-pop cycles expected >0", hits);
      end
      for (int c = 0; c < 8; c++) begin
         idle();
         checks++;
         if (obs_out !== exp_out) begin
            errors++; $display("FAIL full_drain_%0d: got %h expected %h", c, obs_out, exp_out);
         end
      end
   endtask

   task automatic test_ovkill();
      step(3'b001, 15'd9, 96'hDEAD, 3'b001, 3'b001);
      step(3'b001, 15'd0, 96'hBEEF, 3'b001, 3'b000);
      checks++;
      if (obs_out !== {1'b0, 5'd9, 32'hDEAD, 1'b1, 5'd9, 2'd1, 1'b1}) begin
         errors++; $display("FAIL ovkill_first: got %h expected we=0 clr=1 addr=9", obs_out);
      end
      idle();
      checks++;
      if (obs_out !== {1'b0, 5'd0, 32'hBEEF, 1'b1, 5'd0, 2'd1, 1'b0}) begin
         errors++; $display("FAIL ovkill_r0: got %h expected we=0 clr=1 addr=0", obs_out);
      end
   endtask

   task automatic test_reset_mid();
      step(3'b111, {5'd3, 5'd2, 5'd1}, {32'h30, 32'h20, 32'h10}, 3'b111, 3'b000);
      step(3'b011, {5'd0, 5'd5, 5'd4}, {32'h0, 32'h50, 32'h40}, 3'b011, 3'b000);
      rst_n = 1'b0;
      #1;
      checks++;
      if (pack_obs() !== 47'd0 || ifc.fu_wb_ready !== 3'b111) begin
         errors++; $display("FAIL midreset_clear: got %h ready %b expected 0 and 111",
                            pack_obs(), ifc.fu_wb_ready);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      checks++;
      if (obs_out !== 47'd0) begin
         errors++; $display("FAIL midreset_stale: got %h expected 0", obs_out);
      end
      for (int c = 0; c < 10; c++) begin
         step(3'($urandom), 15'($urandom), {$urandom, $urandom, $urandom}, 3'($urandom), 3'($urandom));
         checks++;
         if (obs_ready !== exp_ready || obs_out !== exp_out) begin
            errors++; $display("FAIL midreset_after_%0d: out %h expected %h", c, obs_out, exp_out);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         step(3'($urandom), 15'($urandom), {$urandom, $urandom, $urandom},
              3'($urandom), ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000);
         checks++;
         if (obs_ready !== exp_ready || obs_out !== exp_out) begin
            errors++; $display("FAIL random_%0d: ready %b/%b out %h expected %h",
                               c, obs_ready, exp_ready, obs_out, exp_out);
         end
      end
   endtask

   initial begin
      for (int r = 0; r < 32; r++) rf[r] = '0;
      test_reset();
      @(negedge clk);
      test_single();
      test_all_three();
      test_waw();
      test_full();
      test_ovkill();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
